// File: rtl/arm_pkg.sv
// Shared definitions for the write-back / register-file slice of the pipeline.
package arm_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int CNT_W_DEF  = 32;

    // Index of the program counter; it lives in fetch and is never stored here.
    localparam int PC_IDX_DEF = 15;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] data_word_t;

endpackage

// File: rtl/wb_regfile_stage_if.sv
// MEM/WB bundle, decode read ports and write-back observation signals.
interface wb_regfile_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 32
);
    logic              freeze;
    logic [ADDR_W-1:0] dst_in;
    logic [DATA_W-1:0] alu_res_in;
    logic [DATA_W-1:0] mem_in;
    logic              mem_read_in;
    logic              wb_en_in;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [DATA_W-1:0] reg_val1;
    logic [DATA_W-1:0] reg_val2;
    logic [DATA_W-1:0] wb_value;
    logic [ADDR_W-1:0] wb_dst;
    logic              wb_commit;
    logic [CNT_W-1:0]  wb_count;

    // Pipeline side: MEM/WB register and decode stage.
    modport master (
        output freeze, dst_in, alu_res_in, mem_in, mem_read_in, wb_en_in, src1, src2,
        input  reg_val1, reg_val2, wb_value, wb_dst, wb_commit, wb_count
    );

    // Register-file side.
    modport slave (
        input  freeze, dst_in, alu_res_in, mem_in, mem_read_in, wb_en_in, src1, src2,
        output reg_val1, reg_val2, wb_value, wb_dst, wb_commit, wb_count
    );
endinterface

// File: rtl/wb_regfile_stage_regfile_2r1w.sv
// Storage array with two combinational read ports and one write port.
// Only indices below DEPTH are stored; higher indices read as zero and
// writes to them are dropped.
module wb_regfile_stage_regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Array update: async clear, single write per edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we && (int'(waddr) < DEPTH)) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read ports: plain array lookup, out-of-range indices return zero.
    always_comb begin
        rdata1 = {DATA_W{1'b0}};
        rdata2 = {DATA_W{1'b0}};
        if (int'(raddr1) < DEPTH) begin
            rdata1 = mem_r[raddr1];
        end else begin
            rdata1 = {DATA_W{1'b0}};
        end
        if (int'(raddr2) < DEPTH) begin
            rdata2 = mem_r[raddr2];
        end else begin
            rdata2 = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage fused with the architectural register file: selects the
// write-back value, commits it, serves two bypassed read ports and counts
// committed writes.
module wb_regfile_stage
    import arm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PC_IDX = PC_IDX_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    wb_regfile_stage_if.slave bus
);

    localparam logic [ADDR_W-1:0] PC_SEL = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0] wb_value_s;
    logic              commit_s;
    logic [DATA_W-1:0] arr_val1_s;
    logic [DATA_W-1:0] arr_val2_s;
    logic [DATA_W-1:0] reg_val1_s;
    logic [DATA_W-1:0] reg_val2_s;
    logic [CNT_W-1:0]  wb_count_r;

    // Value select and commit qualification; reset low blocks any commit.
    always_comb begin
        wb_value_s = {DATA_W{1'b0}};
        commit_s   = 1'b0;
        if (bus.mem_read_in) begin
            wb_value_s = bus.mem_in;
        end else begin
            wb_value_s = bus.alu_res_in;
        end
        commit_s = bus.wb_en_in & ~bus.freeze & (bus.dst_in != PC_SEL) & rst;
    end

    wb_regfile_stage_regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (PC_IDX)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (commit_s),
        .waddr  (bus.dst_in),
        .wdata  (wb_value_s),
        .raddr1 (bus.src1),
        .raddr2 (bus.src2),
        .rdata1 (arr_val1_s),
        .rdata2 (arr_val2_s)
    );

    // Read ports: PC reads zero, a same-cycle commit to the read index wins.
    always_comb begin
        reg_val1_s = {DATA_W{1'b0}};
        reg_val2_s = {DATA_W{1'b0}};
        if (bus.src1 == PC_SEL) begin
            reg_val1_s = {DATA_W{1'b0}};
        end else if (commit_s && (bus.dst_in == bus.src1)) begin
            reg_val1_s = wb_value_s;
        end else begin
            reg_val1_s = arr_val1_s;
        end
        if (bus.src2 == PC_SEL) begin
            reg_val2_s = {DATA_W{1'b0}};
        end else if (commit_s && (bus.dst_in == bus.src2)) begin
            reg_val2_s = wb_value_s;
        end else begin
            reg_val2_s = arr_val2_s;
        end
    end

    // Committed-writeback counter, wraps naturally at its width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_count_r <= {CNT_W{1'b0}};
        end else if (commit_s) begin
            wb_count_r <= wb_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wb_count_r <= wb_count_r;
        end
    end

    assign bus.wb_value  = wb_value_s;
    assign bus.wb_dst    = bus.dst_in;
    assign bus.wb_commit = commit_s;
    assign bus.reg_val1  = reg_val1_s;
    assign bus.reg_val2  = reg_val2_s;
    assign bus.wb_count  = wb_count_r;

endmodule
